// File: rtl/event_coord_writer_if.sv
// Coordinate handshake and event-FIFO write bus for event_coord_writer.
// master: coordinate producer / FIFO side; slave: the writer block.
interface event_coord_writer_if #(
    parameter int COORD_BITS = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [COORD_BITS-1:0]   in_x;
    logic [COORD_BITS-1:0]   in_y;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [2*COORD_BITS-1:0] fifo_wr_data;

    modport master (
        output in_valid, in_x, in_y, fifo_full,
        input  in_ready, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  in_valid, in_x, in_y, fifo_full,
        output in_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/event_coord_writer.sv
// Event coordinate writer: accepts (x,y) spikes, bounds-checks them, packs
// valid ones as {x,y} into the event FIFO and emits an EOF marker on request.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a coordinate, or launching a pending EOF marker
// VALIDATE  | latched coordinate being compared against image bounds
// WRITE     | valid coordinate waiting for FIFO space, then written
// EOF_WRITE | EOF marker waiting for FIFO space, then written
module event_coord_writer #(
    parameter int                          IMG_WIDTH  = 32,
    parameter int                          IMG_HEIGHT = 32,
    parameter int                          COORD_BITS = 8,
    parameter int                          CNT_BITS   = 16,
    parameter logic [2*COORD_BITS-1:0]     EOF_MARKER = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    event_coord_writer_if.slave   bus,
    input  logic                  frame_done,
    output logic [CNT_BITS-1:0]   event_count,
    output logic [CNT_BITS-1:0]   drop_count,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        VALIDATE  = 2'd1,
        WRITE     = 2'd2,
        EOF_WRITE = 2'd3
    } state_t;

    localparam logic [31:0] X_LIM = 32'(IMG_WIDTH);
    localparam logic [31:0] Y_LIM = 32'(IMG_HEIGHT);

    state_t                state;
    logic [COORD_BITS-1:0] lat_x;
    logic [COORD_BITS-1:0] lat_y;
    logic                  eof_pending;
    logic                  transfer;

    // Ready only when idle with no marker queued; held low through reset.
    always_comb begin
        bus.in_ready = rst_n && (state == IDLE) && !eof_pending;
        transfer     = bus.in_valid && bus.in_ready;
        busy         = (state != IDLE) || eof_pending;
    end

    // Sequencing FSM with registered FIFO strobe/data and status counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lat_x            <= '0;
            lat_y            <= '0;
            eof_pending      <= 1'b0;
            bus.fifo_wr_en   <= 1'b0;
            bus.fifo_wr_data <= '0;
            event_count      <= '0;
            drop_count       <= '0;
        end else begin
            bus.fifo_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (eof_pending) begin
                        state <= EOF_WRITE;
                    end else if (transfer) begin
                        lat_x <= bus.in_x;
                        lat_y <= bus.in_y;
                        state <= VALIDATE;
                    end
                end
                VALIDATE: begin
                    if ((32'(lat_x) < X_LIM) && (32'(lat_y) < Y_LIM)) begin
                        state <= WRITE;
                    end else begin
                        if (drop_count != '1) drop_count <= drop_count + 1'b1;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (!bus.fifo_full) begin
                        bus.fifo_wr_en   <= 1'b1;
                        bus.fifo_wr_data <= {lat_x, lat_y};
                        if (event_count != '1) event_count <= event_count + 1'b1;
                        state <= IDLE;
                    end
                end
                EOF_WRITE: begin
                    if (!bus.fifo_full) begin
                        bus.fifo_wr_en   <= 1'b1;
                        bus.fifo_wr_data <= EOF_MARKER;
                        eof_pending      <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new request always wins over the clear, so none is lost.
            if (frame_done) eof_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_event_coord_writer.sv
// Bench for event_coord_writer: directed scenarios plus randomized
// coordinates under random back-pressure, checked against a queue model.
module tb_event_coord_writer;

    localparam int W = 32;
    localparam int H = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_done = 1'b0;
    logic [15:0] event_count;
    logic [15:0] drop_count;
    logic busy;

    event_coord_writer_if #(.COORD_BITS(8)) bus ();

    event_coord_writer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_BITS(8), .CNT_BITS(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .frame_done(frame_done),
        .event_count(event_count), .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int exp_events = 0;
    int exp_drops = 0;
    int full_viol = 0;
    logic full_at_edge = 1'b0;
    logic [15:0] got_q[$];

    // Capture the fifo_full value each decision edge saw.
    always @(posedge clk) full_at_edge <= bus.fifo_full;

    // Record every FIFO write; flag any write issued against a full FIFO.
    always @(negedge clk) begin
        if (rst_n && bus.fifo_wr_en) begin
            got_q.push_back(bus.fifo_wr_data);
            if (full_at_edge) full_viol++;
        end
    end

    function automatic bit in_bounds(input int x, input int y);
        return (x < W) && (y < H);
    endfunction

    // Present a coordinate; return at the negedge after the accepting edge.
    task automatic send(input logic [7:0] x, input logic [7:0] y,
                        input logic fd, input bit rnd);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_x = x;
        bus.in_y = y;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
            if (rnd) bus.fifo_full = ($urandom_range(0, 2) == 0);
        end
        if (n >= 300) begin
            checks++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
        end
        frame_done = fd;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        frame_done = 1'b0;
        if (rnd) bus.fifo_full = ($urandom_range(0, 2) == 0);
        if (in_bounds(int'(x), int'(y))) exp_events++;
        else exp_drops++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("FAIL drain_timeout: busy=%0b after %0d cycles, required 0", busy, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x = 8'd1;
        bus.in_y = 8'd1;
        bus.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); else passes++;
        checks++; if (bus.fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", bus.fifo_wr_en); else passes++;
        checks++; if (bus.fifo_wr_data !== 16'h0) $display("FAIL reset_wr_data: got %h want 0000", bus.fifo_wr_data); else passes++;
        checks++; if (event_count !== 16'h0) $display("FAIL reset_event_count: got %0d want 0", event_count); else passes++;
        checks++; if (drop_count !== 16'h0) $display("FAIL reset_drop_count: got %0d want 0", drop_count); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passes++;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %0b want 1", bus.in_ready); else passes++;
    endtask

    task automatic test_basic();
        int n;
        int base;
        base = got_q.size();
        send(8'd5, 8'd7, 1'b0, 1'b0);
        n = 0;
        while (!bus.fifo_wr_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 2) $display("FAIL basic_latency: got %0d cycles want 2", n); else passes++;
        checks++; if (bus.fifo_wr_data !== 16'h0507) $display("FAIL basic_data: got %h want 0507", bus.fifo_wr_data); else passes++;
        checks++; if (event_count !== 16'(exp_events)) $display("FAIL basic_event_count: got %0d want %0d", event_count, exp_events); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL basic_ready_again: got %0b want 1", bus.in_ready); else passes++;
        @(negedge clk);
        checks++; if (bus.fifo_wr_en !== 1'b0) $display("FAIL basic_single_pulse: got %0b want 0", bus.fifo_wr_en); else passes++;
        checks++; if (got_q.size() - base !== 1) $display("FAIL basic_write_count: got %0d want 1", got_q.size() - base); else passes++;
    endtask

    task automatic test_bounds();
        int base;
        base = got_q.size();
        send(8'd32, 8'd0, 1'b0, 1'b0);
        drain();
        send(8'd0, 8'd32, 1'b0, 1'b0);
        drain();
        checks++; if (got_q.size() !== base) $display("FAIL bounds_no_write: got %0d writes want 0", got_q.size() - base); else passes++;
        checks++; if (drop_count !== 16'(exp_drops)) $display("FAIL bounds_drop_count: got %0d want %0d", drop_count, exp_drops); else passes++;
        send(8'd31, 8'd31, 1'b0, 1'b0);
        drain();
        checks++; if (got_q.size() - base !== 1) $display("FAIL bounds_corner_count: got %0d want 1", got_q.size() - base); else passes++;
        if (got_q.size() > base) begin
            checks++; if (got_q[base] !== 16'h1F1F) $display("FAIL bounds_corner_data: got %h want 1f1f", got_q[base]); else passes++;
        end
        checks++; if (event_count !== 16'(exp_events)) $display("FAIL bounds_event_count: got %0d want %0d", event_count, exp_events); else passes++;
    endtask

    task automatic test_backpressure();
        int base;
        bit en_seen;
        bit rdy_seen;
        base = got_q.size();
        en_seen = 1'b0;
        rdy_seen = 1'b0;
        bus.fifo_full = 1'b1;
        send(8'd3, 8'd4, 1'b0, 1'b0);
        repeat (10) begin
            @(negedge clk);
            if (bus.fifo_wr_en) en_seen = 1'b1;
            if (bus.in_ready) rdy_seen = 1'b1;
        end
        checks++; if (en_seen !== 1'b0) $display("FAIL bp_wr_en_held: got %0b want 0", en_seen); else passes++;
        checks++; if (rdy_seen !== 1'b0) $display("FAIL bp_ready_held: got %0b want 0", rdy_seen); else passes++;
        bus.fifo_full = 1'b0;
        drain();
        checks++; if (got_q.size() - base !== 1) $display("FAIL bp_write_count: got %0d want 1", got_q.size() - base); else passes++;
        if (got_q.size() > base) begin
            checks++; if (got_q[base] !== 16'h0304) $display("FAIL bp_data: got %h want 0304", got_q[base]); else passes++;
        end
    endtask

    task automatic test_eof_same_cycle();
        int base;
        int ev0;
        bit rdy_seen;
        base = got_q.size();
        ev0 = exp_events;
        rdy_seen = 1'b0;
        send(8'd1, 8'd2, 1'b1, 1'b0);
        repeat (4) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (rdy_seen !== 1'b0) $display("FAIL eof_ready_low: got %0b want 0", rdy_seen); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL eof_ready_after: got %0b want 1", bus.in_ready); else passes++;
        drain();
        checks++; if (got_q.size() - base !== 2) $display("FAIL eof_write_count: got %0d want 2", got_q.size() - base); else passes++;
        if (got_q.size() - base >= 2) begin
            checks++; if (got_q[base] !== 16'h0102) $display("FAIL eof_first_data: got %h want 0102", got_q[base]); else passes++;
            checks++; if (got_q[base+1] !== 16'hFFFF) $display("FAIL eof_marker_data: got %h want ffff", got_q[base+1]); else passes++;
        end
        checks++; if (event_count !== 16'(ev0 + 1)) $display("FAIL eof_event_count: got %0d want %0d", event_count, ev0 + 1); else passes++;
    endtask

    task automatic test_eof_collapse();
        int base;
        base = got_q.size();
        bus.fifo_full = 1'b1;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        repeat (3) @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (got_q.size() !== base) $display("FAIL collapse_held: got %0d writes want 0", got_q.size() - base); else passes++;
        bus.fifo_full = 1'b0;
        drain();
        checks++; if (got_q.size() - base !== 1) $display("FAIL collapse_count: got %0d want 1", got_q.size() - base); else passes++;
        if (got_q.size() > base) begin
            checks++; if (got_q[base] !== 16'hFFFF) $display("FAIL collapse_data: got %h want ffff", got_q[base]); else passes++;
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_q[$];
        logic [7:0] x;
        logic [7:0] y;
        int base;
        int m;
        base = got_q.size();
        for (int i = 0; i < 30; i++) begin
            x = 8'($urandom_range(0, 40));
            y = 8'($urandom_range(0, 40));
            if (in_bounds(int'(x), int'(y))) exp_q.push_back({x, y});
            send(x, y, 1'b0, 1'b1);
        end
        bus.fifo_full = 1'b0;
        drain();
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        exp_q.push_back(16'hFFFF);
        drain();
        checks++; if (got_q.size() - base !== exp_q.size()) $display("FAIL rand_write_count: got %0d want %0d", got_q.size() - base, exp_q.size()); else passes++;
        m = got_q.size() - base;
        if (m > exp_q.size()) m = exp_q.size();
        for (int i = 0; i < m; i++) begin
            checks++; if (got_q[base+i] !== exp_q[i]) $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]); else passes++;
        end
        checks++; if (event_count !== 16'(exp_events)) $display("FAIL rand_event_count: got %0d want %0d", event_count, exp_events); else passes++;
        checks++; if (drop_count !== 16'(exp_drops)) $display("FAIL rand_drop_count: got %0d want %0d", drop_count, exp_drops); else passes++;
        checks++; if (full_viol !== 0) $display("FAIL rand_write_while_full: got %0d want 0", full_viol); else passes++;
    endtask

    task automatic test_reset_mid();
        int base;
        bus.fifo_full = 1'b1;
        send(8'd9, 8'd9, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.fifo_wr_en !== 1'b0) $display("FAIL rmid_wr_en: got %0b want 0", bus.fifo_wr_en); else passes++;
        checks++; if (bus.fifo_wr_data !== 16'h0) $display("FAIL rmid_wr_data: got %h want 0000", bus.fifo_wr_data); else passes++;
        checks++; if (event_count !== 16'h0) $display("FAIL rmid_event_count: got %0d want 0", event_count); else passes++;
        checks++; if (drop_count !== 16'h0) $display("FAIL rmid_drop_count: got %0d want 0", drop_count); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %0b want 0", busy); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %0b want 0", bus.in_ready); else passes++;
        exp_events = 0;
        exp_drops = 0;
        @(negedge clk);
        base = got_q.size();
        rst_n = 1'b1;
        bus.fifo_full = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (got_q.size() !== base) $display("FAIL rmid_stale_write: got %0d writes want 0", got_q.size() - base); else passes++;
        checks++; if (event_count !== 16'h0) $display("FAIL rmid_event_after: got %0d want 0", event_count); else passes++;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_bounds();
        test_backpressure();
        test_eof_same_cycle();
        test_eof_collapse();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/event_coord_writer.md
Name: event_coord_writer

Overview:
- Producer-side counterpart to the conv/pool event capture path.
- Accepts (x,y) spike coordinates from the pooling/output stage over a valid/ready handshake and checks each against image bounds.
- Packs valid coordinates as {x,y} (x in the upper COORD_BITS) and writes them one word at a time into the downstream event FIFO.
- Drops out-of-range coordinates and counts them. On request, emits an end-of-frame marker word.

Parameters:
- IMG_WIDTH, 32, image width; x is valid iff x < IMG_WIDTH
- IMG_HEIGHT, 32, image height; y is valid iff y < IMG_HEIGHT
- COORD_BITS, 8, bits per coordinate; FIFO word is 2*COORD_BITS
- CNT_BITS, 16, width of the status counters
- EOF_MARKER, all-ones (2*COORD_BITS), end-of-frame word; out of range for the default image size

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  coordinate present
- in_ready  out  1  block accepts a coordinate this cycle
- in_x  in  COORD_BITS  x coordinate
- in_y  in  COORD_BITS  y coordinate
- frame_done  in  1  single-cycle pulse requesting an EOF marker
- fifo_full  in  1  downstream FIFO cannot accept a write
- fifo_wr_en  out  1  write strobe, one cycle per word
- fifo_wr_data  out  2*COORD_BITS  packed {x,y} or EOF_MARKER
- event_count  out  CNT_BITS  coordinates written (EOF excluded)
- drop_count  out  CNT_BITS  coordinates rejected as out of range
- busy  out  1  state != IDLE or EOF pending

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=0 while in reset.
  - fifo_wr_en=0, fifo_wr_data=0, event_count=0, drop_count=0, eof_pending=0, busy=0.
  - Latched coordinate cleared.
  - Reset mid-operation aborts any pending write or EOF with no FIFO write.
- States: IDLE, VALIDATE, WRITE, EOF_WRITE.
- in_ready = (state==IDLE) && !eof_pending (combinational). A transfer occurs on in_valid && in_ready at a rising edge.
- eof_pending:
  - Set on any cycle with frame_done=1, in any state.
  - Cleared in the cycle the EOF word is written.
  - Repeated frame_done pulses while pending collapse into one marker.
- IDLE:
  - If eof_pending, go to EOF_WRITE.
  - Else on transfer, latch {in_x,in_y] and go to VALIDATE.
- Same-cycle frame_done and transfer: the coordinate is accepted (in_ready was already 1) and eof_pending is set. The marker therefore follows that coordinate.
- VALIDATE:
  - If x<IMG_WIDTH && y<IMG_HEIGHT, go to WRITE.
  - Else drop_count++ (saturating at 2^CNT_BITS-1) and go to IDLE; no FIFO write.
- WRITE:
  - If !fifo_full: fifo_wr_en=1 and fifo_wr_data={x,y} for exactly one cycle, event_count++ (saturating), go to IDLE.
  - If fifo_full: stay in WRITE with fifo_wr_en=0; the latched coordinate is held indefinitely.
- EOF_WRITE:
  - If !fifo_full: fifo_wr_en=1, fifo_wr_data=EOF_MARKER, clear eof_pending, go to IDLE.
  - Else wait. Counters are unaffected.
- Outputs fifo_wr_en and fifo_wr_data are registered, asserted in the cycle after the state decision.
  - fifo_wr_data holds its last value when fifo_wr_en=0.
  - fifo_full is sampled in the same cycle the decision is made; a write is never issued while fifo_full=1 was observed.
- Latency, from accept edge to fifo_wr_en high, with FIFO not full:
  - 2 cycles for a valid coordinate.
  - Peak throughput is 1 event per 3 cycles.
- Boundaries:
  - x=IMG_WIDTH-1, y=IMG_HEIGHT-1 is valid.
  - x=IMG_WIDTH or y=IMG_HEIGHT is dropped.
  - Counter saturation never wraps.

Test Plan:
- Reset, then in_x=5, in_y=7 with fifo_full=0 -> one fifo_wr_en pulse 2 cycles after accept, fifo_wr_data=16'h0507, event_count=1, in_ready=1 again on the next cycle.
- in_x=32, in_y=0, then in_x=0, in_y=32 -> no FIFO writes, drop_count=2. Then (31,31) -> write 16'h1F1F.
- Accept (3,4) with fifo_full=1 for 10 cycles -> fifo_wr_en stays 0 and in_ready stays 0. Release fifo_full -> exactly one write of 16'h0304.
- frame_done in the same cycle as accepting (1,2) -> write 16'h0102 first, then 16'hFFFF. in_ready=0 until the marker is written. event_count increments by 1 only.
- Two frame_done pulses while fifo_full=1 -> exactly one 16'hFFFF after release.
- Assert rst_n=0 while in WRITE with fifo_full=1 -> all outputs and counters reset to 0 immediately. Deassert rst_n and clear fifo_full -> no stale write.
